// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245R stream bridge.
package ft245_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_STROBE = 3'd1,
    WR_HOLD   = 3'd2,
    RD_STROBE = 3'd3,
    RD_LATCH  = 3'd4,
    GAP       = 3'd5
  } state_e;

  localparam logic [7:0] FRAME_MARKER = 8'hA5;
  localparam int         DROP_CNT_W   = 16;
  localparam int         MAX_PUSH     = 5;
  localparam logic       ARB_TX       = 1'b0;
  localparam logic       ARB_RX       = 1'b1;
endpackage

// File: rtl/ft245_byte_fifo.sv
// Byte FIFO: up to MAX_PUSH bytes pushed per cycle (push_data[0] first),
// single pop, show-ahead head. Caller guarantees room / non-empty.
module byte_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2:0]                      push_cnt,
  input  logic [MAX_PUSH-1:0][7:0]        push_data,
  input  logic                            pop,
  output logic [7:0]                      head,
  output logic [$clog2(DEPTH):0]          level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_cnt);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push_cnt) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; level counters define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_PUSH; i++)
      if (3'(i) < push_cnt) mem_q[wr_ptr_q + AW'(i)] <= push_data[i];
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
endmodule

// File: rtl/ft245_stream_bridge.sv
// Sample producer / host command bridge to an FT245R USB FIFO.
// Optional FRAME_MARKER_EN: prefix each accepted sample with 0xA5.
module ft245_stream_bridge
  import ft245_pkg::*;
#(
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 8,
  parameter int SAMPLE_BYTES = 2,
  parameter int STROBE_CYC   = 4,
  parameter int GAP_CYC      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*SAMPLE_BYTES-1:0]     sample_data,
  input  logic                          sample_valid,
  output logic                          sample_drop,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic [$clog2(TX_DEPTH):0]     tx_level,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [7:0]                    usb_data_in,
  output logic [7:0]                    usb_data_out,
  output logic                          usb_data_oe,
  output logic                          usb_wr,
  output logic                          usb_rd_n,
  input  logic                          usb_txe_n,
  input  logic                          usb_rxf_n
);
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;
`ifdef FRAME_MARKER_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int NEED = SAMPLE_BYTES + OFS;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     arb_q, arb_d;
  logic [7:0]               data_q, data_d, rx_byte_q, rx_byte_d;
  logic                     txe_meta_q, txe_sync_q, rxf_meta_q, rxf_sync_q;
  logic                     drop_q, drop_d;
  logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                     tx_pop, rx_push, rx_pop, accept, tx_ok, rx_ok;
  logic [2:0]               tx_push_cnt;
  logic [MAX_PUSH-1:0][7:0] tx_push_data;
  logic [7:0]               tx_head;
  logic [RLW-1:0]           rx_level;
  logic [TLW-1:0]           tx_free;

  // Free space is taken from the registered level, i.e. before any pop this cycle.
  assign tx_free     = TLW'(TX_DEPTH) - tx_level;
  assign accept      = sample_valid && (tx_free >= TLW'(NEED));
  assign tx_push_cnt = accept ? 3'(NEED) : 3'd0;

  always_comb begin
    tx_push_data = '0;
`ifdef FRAME_MARKER_EN
    tx_push_data[0] = FRAME_MARKER;
`endif
    for (int i = 0; i < SAMPLE_BYTES; i++)
      tx_push_data[i+OFS] = sample_data[8*(SAMPLE_BYTES-1-i) +: 8];
  end

  always_comb begin
    drop_d     = sample_valid && !accept;
    drop_cnt_d = drop_cnt_q;
    if (drop_d && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push_cnt(tx_push_cnt), .push_data(tx_push_data),
    .pop(tx_pop), .head(tx_head), .level(tx_level)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push_cnt({2'b00, rx_push}),
    .push_data({32'd0, rx_byte_q}),
    .pop(rx_pop), .head(rx_data), .level(rx_level)
  );

  assign rx_valid = rx_level != '0;
  assign rx_pop   = rx_valid && rx_ready;
  assign tx_ok    = (tx_level != '0) && !txe_sync_q;
  assign rx_ok    = !rxf_sync_q && (rx_level != RLW'(RX_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      arb_q      <= ARB_TX;
      data_q     <= '0;
      rx_byte_q  <= '0;
      txe_meta_q <= 1'b1;
      txe_sync_q <= 1'b1;
      rxf_meta_q <= 1'b1;
      rxf_sync_q <= 1'b1;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arb_q      <= arb_d;
      data_q     <= data_d;
      rx_byte_q  <= rx_byte_d;
      txe_meta_q <= usb_txe_n;
      txe_sync_q <= txe_meta_q;
      rxf_meta_q <= usb_rxf_n;
      rxf_sync_q <= rxf_meta_q;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arb_d     = arb_q;
    data_d    = data_q;
    rx_byte_d = rx_byte_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ok && (!rx_ok || arb_q == ARB_TX)) begin
          state_d = WR_STROBE;
          data_d  = tx_head;
          cnt_d   = 4'(STROBE_CYC - 1);
          arb_d   = ARB_RX;
        end else if (rx_ok) begin
          state_d = RD_STROBE;
          cnt_d   = 4'(STROBE_CYC - 1);
          arb_d   = ARB_TX;
        end
      end
      WR_STROBE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
          tx_pop  = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      WR_HOLD: begin
        state_d = GAP;
        cnt_d   = 4'(GAP_CYC - 1);
      end
      // Capture on the last strobe edge, while RD# is still low.
      RD_STROBE: begin
        if (cnt_q == '0) begin
          state_d   = RD_LATCH;
          rx_byte_d = usb_data_in;
        end else cnt_d = cnt_q - 1'b1;
      end
      RD_LATCH: begin
        rx_push = 1'b1;
        state_d = GAP;
        cnt_d   = 4'(GAP_CYC - 1);
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    usb_wr       = state_q == WR_STROBE;
    usb_rd_n     = state_q != RD_STROBE;
    usb_data_oe  = (state_q == WR_STROBE) || (state_q == WR_HOLD);
    usb_data_out = usb_data_oe ? data_q : 8'h00;
  end

  assign sample_drop = drop_q;
  assign drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_ft245_stream_bridge.sv
// Scoreboard bench for ft245_stream_bridge; build with FRAME_MARKER_EN to cover the marker mode.
module tb_ft245_stream_bridge;
  localparam int TXD = 16, RXD = 8, SB = 2, STB = 4, GAPC = 4;
`ifdef FRAME_MARKER_EN
  localparam int NEED = SB + 1;
`else
  localparam int NEED = SB;
`endif

  logic        clk = 0, reset = 1;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 0, sample_drop;
  logic [15:0] drop_count;
  logic [4:0]  tx_level;
  logic [7:0]  rx_data, usb_data_in, usb_data_out;
  logic        rx_valid, rx_ready = 0, usb_data_oe, usb_wr, usb_rd_n;
  logic        usb_txe_n = 1, usb_rxf_n;

  int n_tests = 0, n_fail = 0;
  int model_lvl = 0, model_drops = 0;
  int wr_cnt = 0, rd_cnt = 0, wr_run = 0, rd_run = 0, quiet = 0;
  int acc_total = 0, acc_base = 0, last_kind = 0;
  logic chk_gap = 0, host_en = 0;
  logic [7:0] wr_byte;
  logic [7:0] host_mem [16];
  logic [4:0] host_rd = 0, host_wr = 0;
  logic [7:0] exp_tx [$];
  logic [7:0] exp_rx [$];

  always #5 clk = ~clk;

  assign usb_data_in = host_mem[host_rd[3:0]];
  assign usb_rxf_n   = !(host_en && host_rd != host_wr);

  ft245_stream_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .SAMPLE_BYTES(SB),
                        .STROBE_CYC(STB), .GAP_CYC(GAPC)) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_drop(sample_drop), .drop_count(drop_count), .tx_level(tx_level),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out), .usb_data_oe(usb_data_oe),
    .usb_wr(usb_wr), .usb_rd_n(usb_rd_n), .usb_txe_n(usb_txe_n), .usb_rxf_n(usb_rxf_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    logic acc;
    acc = (TXD - model_lvl) >= NEED;
    @(posedge clk); #1;
    sample_data = d; sample_valid = 1;
    if (acc) begin
`ifdef FRAME_MARKER_EN
      exp_tx.push_back(8'hA5);
`endif
      exp_tx.push_back(d[15:8]);
      exp_tx.push_back(d[7:0]);
      model_lvl += NEED;
    end else model_drops++;
    @(posedge clk); #1;
    sample_valid = 0;
    chk("sample_drop", sample_drop, !acc);
  endtask

  task automatic host_load(input logic [7:0] b);
    host_mem[host_wr[3:0]] = b;
    host_wr = host_wr + 1'b1;
    exp_rx.push_back(b);
  endtask

  task automatic note_access(input int kind);
    if (chk_gap && acc_total > acc_base && acc_total - acc_base < 10) begin
      chk("arb_alt", kind != last_kind, 1);
      chk("gap_len", quiet, (last_kind == 1) ? GAPC + 2 : GAPC + 1);
    end
    acc_total++;
    last_kind = kind;
  endtask

  // Bus monitor: strobe widths, write hold, TX/RX byte scoreboards, gaps.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      wr_run = 0; rd_run = 0; quiet = 0;
    end else begin
      if (usb_wr) begin
        if (wr_run == 0) begin wr_byte = usb_data_out; note_access(0); end
        else chk("wr_data_stable", usb_data_out, wr_byte);
        wr_run++;
      end else if (wr_run > 0) begin
        chk("wr_width", wr_run, STB);
        chk("wr_hold_oe", usb_data_oe, 1);
        chk("wr_hold_data", usb_data_out, wr_byte);
        if (exp_tx.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", wr_byte, exp_tx.pop_front());
        wr_cnt++; wr_run = 0; quiet = 0;
      end
      if (!usb_rd_n) begin
        if (rd_run == 0) note_access(1);
        rd_run++;
      end else if (rd_run > 0) begin
        chk("rd_width", rd_run, STB);
        rd_cnt++; rd_run = 0; quiet = 0;
        host_rd = host_rd + 1'b1;
      end
      if (!usb_wr && usb_rd_n && !usb_data_oe) quiet++;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) chk("rx_extra", 1, 0);
        else chk("rx_byte", rx_data, exp_rx.pop_front());
      end
    end
  end

  initial begin
    int base, i, n;
    cyc(3);
    reset = 0;
    cyc(1);
    chk("rst_wr", usb_wr, 0);
    chk("rst_rd_n", usb_rd_n, 1);
    chk("rst_oe", usb_data_oe, 0);
    chk("rst_data", usb_data_out, 0);
    chk("rst_drop", sample_drop, 0);
    chk("rst_drop_cnt", drop_count, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_valid", rx_valid, 0);

    // Single sample written straight out
    usb_txe_n = 0;
    base = wr_cnt;
    send(16'h1234);
    for (i = 0; i < 200 && (wr_cnt - base < NEED || tx_level != 0); i++) cyc(1);
    chk("t1_writes", wr_cnt - base, NEED);
    chk("t1_tx_level", tx_level, 0);
    model_lvl = 0;

    // Fill with TXE# high until one sample is dropped
    usb_txe_n = 1;
    cyc(4);
    base = wr_cnt;
    n = TXD / NEED + 1;
    for (int k = 0; k < n; k++) send(16'(16'hBEEF + k));
    cyc(5);
    chk("t2_drop_cnt", drop_count, model_drops);
    chk("t2_tx_level", tx_level, model_lvl);
    chk("t2_no_wr", wr_cnt - base + wr_run, 0);
    usb_txe_n = 0;
    for (i = 0; i < 1000 && (tx_level != 0 || exp_tx.size() != 0); i++) cyc(1);
    chk("t2_drained", exp_tx.size(), 0);
    model_lvl = 0;

    // Both sides ready: accesses must alternate with fixed gaps
    usb_txe_n = 1;
    cyc(4);
    for (int k = 0; k < 3; k++) send(16'(16'hC0D0 + 16'h0101 * k));
    for (int k = 0; k < 6; k++) host_load(8'(8'h40 + k));
    rx_ready = 1;
    acc_base = acc_total;
    chk_gap = 1;
    usb_txe_n = 0;
    host_en = 1;
    for (i = 0; i < 1000 && (exp_tx.size() != 0 || exp_rx.size() != 0); i++) cyc(1);
    chk_gap = 0;
    chk("t3_acc_cnt", acc_total - acc_base >= 10, 1);
    chk("t3_rx_done", exp_rx.size(), 0);
    model_lvl = 0;

    // RX FIFO fills; reads stop until the consumer drains it
    rx_ready = 0;
    usb_txe_n = 1;
    base = rd_cnt;
    for (int k = 1; k <= 9; k++) host_load(8'(k));
    for (i = 0; i < 400 && rd_cnt - base < RXD; i++) cyc(1);
    cyc(40);
    chk("t4_reads_full", rd_cnt - base, RXD);
    chk("t4_rd_n_idle", usb_rd_n, 1);
    chk("t4_rx_valid", rx_valid, 1);
    chk("t4_rx_head", rx_data, 8'h01);
    rx_ready = 1;
    for (i = 0; i < 400 && (rd_cnt - base < 9 || exp_rx.size() != 0); i++) cyc(1);
    chk("t4_reads_all", rd_cnt - base, 9);
    chk("t4_rx_done", exp_rx.size(), 0);
    host_en = 0;

    // Reset in the middle of a write strobe
    send(16'h5A5A);
    usb_txe_n = 0;
    for (i = 0; i < 50 && !usb_wr; i++) cyc(1);
    chk("t5_wr_seen", usb_wr, 1);
    reset = 1;
    cyc(1);
    chk("t5_wr", usb_wr, 0);
    chk("t5_oe", usb_data_oe, 0);
    chk("t5_tx_level", tx_level, 0);
    chk("t5_drop_cnt", drop_count, 0);
    exp_tx.delete();
    cyc(1);
    reset = 0;
    cyc(20);
    chk("t5_quiet_wr", usb_wr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ft245_stream_bridge.md
Name: ft245_stream_bridge

Overview:
Parametrised bridge between the on-board sample producer (ADC path) and an FT245R USB FIFO.
- TX path: accepts multi-byte samples, buffers them as bytes in a TX FIFO and writes them to the FT245R.
- RX path: reads host bytes into an RX FIFO exposed to a valid/ready consumer (command decoder).
- Bus strobe widths and inter-access gaps are parameters; TX/RX arbitration is fair.

Parameters:
TX_DEPTH, 16, TX byte FIFO depth; power of 2, >= SAMPLE_BYTES+1
RX_DEPTH, 8, RX byte FIFO depth; power of 2, >= 2
SAMPLE_BYTES, 2, bytes per sample; 1..4
STROBE_CYC, 4, clk cycles usb_wr high / usb_rd_n low; 1..15
GAP_CYC, 4, idle cycles after every bus access; 2..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_data  in  8*SAMPLE_BYTES  sample word, MS byte sent first
sample_valid  in  1  one-cycle pulse, sample present
sample_drop  out  1  one-cycle pulse, sample discarded (no room)
drop_count  out  16  saturating count of dropped samples
tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
rx_data  out  8  head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer pops when rx_valid&&rx_ready
usb_data_in  in  8  FT245R data bus, input side
usb_data_out  out  8  FT245R data bus, drive value
usb_data_oe  out  1  tristate enable, applied at top level
usb_wr  out  1  FT245R WR (active high, data latched on falling edge)
usb_rd_n  out  1  FT245R RD#
usb_txe_n  in  1  FT245R TXE#, async
usb_rxf_n  in  1  FT245R RXF#, async

Behaviour:
- Reset values: usb_wr=0, usb_rd_n=1, usb_data_oe=0, usb_data_out=0, sample_drop=0, drop_count=0, both FIFOs empty, rx_valid=0, state=IDLE, arbitration pointer=TX.
- Reset mid-access: bus released within 1 cycle (oe=0, wr=0, rd_n=1), byte in flight lost; synchronizers reset to 1 (inactive).
- usb_txe_n/usb_rxf_n pass through 2-flop synchronizers; all decisions use synchronized values.
- Sample ingest: on sample_valid, if free space >= NEED (SAMPLE_BYTES, +1 with marker), all bytes pushed atomically that cycle, MS byte first; otherwise whole sample dropped, sample_drop pulses next cycle, drop_count++ (saturates at 0xFFFF). Ingest is concurrent with a bus pop in the same cycle; free space is evaluated before that pop.
- FSM states: IDLE, WR_STROBE, WR_HOLD, RD_STROBE, RD_LATCH, GAP.
- IDLE: tx_ok = TX FIFO non-empty && !txe_sync; rx_ok = !rxf_sync && RX FIFO not full.
  - Both set: serve the side indicated by the arbitration pointer, then toggle the pointer.
  - One set: serve it and set the pointer to the other side.
- WR_STROBE: usb_data_out=FIFO head, oe=1, usb_wr=1 for STROBE_CYC cycles.
- WR_HOLD: usb_wr=0, data and oe held 1 cycle; FIFO popped on entry; then GAP with oe=0.
- RD_STROBE: usb_rd_n=0 for STROBE_CYC cycles.
- RD_LATCH: usb_data_in captured (rd_n still 0), pushed to RX FIFO, rd_n=1; then GAP.
- GAP: GAP_CYC cycles, all strobes inactive, then IDLE. Covers the synchronizer delay so a stale TXE#/RXF# is never reused.
- RX FIFO full: no reads issued; host data remains in the FT245R.
- RX pop: rx_data/rx_valid are show-ahead. Push and pop in the same cycle keep the level unchanged.
- Pointer wrap-around is natural (power-of-2 depth); full/empty are determined from level counters.

Optional Feature:
FRAME_MARKER_EN
- Defined: each accepted sample is preceded by byte 0xA5 in the TX FIFO; NEED=SAMPLE_BYTES+1. The marker and its sample are never split, and a drop discards both.
- Undefined: raw sample bytes only; NEED=SAMPLE_BYTES.

Decomposition:
- Package ft245_pkg holds the FSM state encoding, FRAME_MARKER=8'hA5 and DROP_CNT_W=16.
- Sub-module byte_fifo (parameter DEPTH): multi-byte push port (up to 5 bytes per cycle), single pop, show-ahead output, level output. Instantiated twice: TX with multi-push, RX with single push.

Test Plan:
1. SAMPLE_BYTES=2, txe_n=0, sample 16'h1234 -> usb_wr strobes carry 0x12 then 0x34; each wr high 4 cycles with data stable 1 cycle past the falling edge; tx_level returns to 0.
2. txe_n=1, 9 samples into TX_DEPTH=16 -> 8 accepted, 9th gives sample_drop pulse, drop_count=1, tx_level=16, no usb_wr activity.
3. txe_n=0 and rxf_n=0 continuously with TX data pending -> accesses alternate WR, RD, WR, RD; each access followed by exactly 4 idle cycles.
4. Host bytes 0x01..0x09, rx_ready=0, RX_DEPTH=8 -> 8 reads, then usb_rd_n held 1. Raising rx_ready yields 0x01..0x08 in order, then the 9th read occurs.
5. Assert reset during WR_STROBE -> next cycle usb_wr=0, oe=0, tx_level=0, drop_count=0.
6. FRAME_MARKER_EN defined, sample 16'hBEEF -> bus bytes A5, BE, EF; TX_DEPTH=16 accepts 5 samples, 6th dropped.
